// File: rtl/serial_pattern_gen_if.sv
// Bus between a pattern source and the serial_pattern_gen transmitter.
// The master owns the request fields; the slave (transmitter) returns the serial stream and status.
interface serial_pattern_gen_if #(
    parameter int MAX_LEN = 8
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [3:0]         length;
    logic [3:0]         repeat_n;
    logic               w;
    logic               w_valid;
    logic               busy;
    logic               done;
    logic [2:0]         state;

    modport master (
        output start, pattern, length, repeat_n,
        input  w, w_valid, busy, done, state
    );

    modport slave (
        input  start, pattern, length, repeat_n,
        output w, w_valid, busy, done, state
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: shifts a latched pattern out MSB-first, optionally
// repeating it with forced-zero gaps, then pulses done.
//
// state | meaning
// IDLE  | waiting for an accepted start (1 <= length <= MAX_LEN)
// SHIFT | one pattern bit on w per cycle, w_valid high
// GAP   | w=0, w_valid=0 for GAP_CYCLES between repeats
// DONE  | one-cycle done pulse, then back to IDLE
module serial_pattern_gen #(
    parameter int MAX_LEN    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_pattern_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SHIFT = 3'b001,
        ST_GAP   = 3'b010,
        ST_DONE  = 3'b011
    } state_t;

    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);
    localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MAX_LEN-1:0] r_sh;
    logic [MAX_LEN-1:0] w_sh_nxt;
    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] w_pat_nxt;
    logic [3:0]         r_len;
    logic [3:0]         w_len_nxt;
    logic [3:0]         r_bit_cnt;
    logic [3:0]         w_bit_cnt_nxt;
    logic [3:0]         r_rep;
    logic [3:0]         w_rep_nxt;
    logic [3:0]         r_gap;
    logic [3:0]         w_gap_nxt;
    logic               w_len_ok;

    // The first transmitted bit must sit at the shift-register MSB.
    function automatic logic [MAX_LEN-1:0] left_align(input logic [MAX_LEN-1:0] pat,
                                                      input logic [3:0]         len);
        int sa;
        sa = MAX_LEN - int'(len);
        return pat << sa;
    endfunction

    assign w_len_ok = (bus.length != 4'd0) && ({1'b0, bus.length} <= MAX_LEN_W);

    always_comb begin
        w_state_nxt   = r_state;
        w_sh_nxt      = r_sh;
        w_pat_nxt     = r_pat;
        w_len_nxt     = r_len;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rep_nxt     = r_rep;
        w_gap_nxt     = r_gap;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && w_len_ok) begin
                    w_pat_nxt     = bus.pattern;
                    w_len_nxt     = bus.length;
                    w_rep_nxt     = bus.repeat_n;
                    w_sh_nxt      = left_align(bus.pattern, bus.length);
                    w_bit_cnt_nxt = bus.length;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_sh_nxt      = {r_sh[MAX_LEN-2:0], 1'b0};
                w_bit_cnt_nxt = r_bit_cnt - 4'd1;
                if (r_bit_cnt == 4'd1) begin
                    if (r_rep != 4'd0) begin
                        w_gap_nxt   = GAP_LOAD;
                        w_rep_nxt   = r_rep - 4'd1;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                w_gap_nxt = r_gap - 4'd1;
                if (r_gap == 4'd1) begin
                    w_sh_nxt      = left_align(r_pat, r_len);
                    w_bit_cnt_nxt = r_len;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sh      <= '0;
            r_pat     <= '0;
            r_len     <= 4'd0;
            r_bit_cnt <= 4'd0;
            r_rep     <= 4'd0;
            r_gap     <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_sh      <= w_sh_nxt;
            r_pat     <= w_pat_nxt;
            r_len     <= w_len_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_rep     <= w_rep_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

    // Outputs decode registered state only, so w/w_valid cannot glitch mid-cycle.
    assign bus.w       = (r_state == ST_SHIFT) && r_sh[MAX_LEN-1];
    assign bus.w_valid = (r_state == ST_SHIFT);
    assign bus.busy    = (r_state == ST_SHIFT) || (r_state == ST_GAP) || (r_state == ST_DONE);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.state   = r_state;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: directed scenarios plus randomized runs
// compared against a cycle-by-cycle expected stream built from the pattern bits.
module tb_serial_pattern_gen;

    localparam int MAX_LEN = 8;
    localparam int GAP     = 2;

    logic clock;
    logic reset;
    int   n_err;
    int   n_checks;

    serial_pattern_gen_if #(.MAX_LEN(MAX_LEN)) bus ();

    serial_pattern_gen #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] obs();
        return {bus.state, bus.w, bus.w_valid, bus.busy, bus.done};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic launch(input logic [7:0] pat, input int len, input int rep);
        bus.pattern  = pat;
        bus.length   = 4'(len);
        bus.repeat_n = 4'(rep);
        bus.start    = 1'b1;
        @(posedge clock); #1;
    endtask

    // mode 0: hold start=1 with pattern FF while busy; mode 1: random junk on all inputs.
    task automatic expect_run(input logic [7:0] pat, input int len, input int rep, input int mode,
                              input bit chain, input logic [7:0] npat, input int nlen, input int nrep);
        logic [6:0] q[$];
        int busy_n;
        for (int r = 0; r <= rep; r++) begin
            for (int i = len - 1; i >= 0; i--)
                q.push_back({3'd1, pat[i], 1'b1, 1'b1, 1'b0});
            if (r < rep)
                for (int g = 0; g < GAP; g++)
                    q.push_back({3'd2, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        q.push_back({3'd3, 1'b0, 1'b0, 1'b1, 1'b1});
        q.push_back({3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        busy_n = 0;
        for (int j = 0; j < q.size(); j++) begin
            check($sformatf("run p=%02h l=%0d r=%0d cyc%0d", pat, len, rep, j + 1),
                  32'(obs()), 32'(q[j]));
            if (bus.busy) busy_n++;
            if (j == q.size() - 1) begin
                if (chain) begin
                    bus.start    = 1'b1;
                    bus.pattern  = npat;
                    bus.length   = 4'(nlen);
                    bus.repeat_n = 4'(nrep);
                end else begin
                    bus.start = 1'b0;
                end
            end else if (mode == 0) begin
                bus.start   = 1'b1;
                bus.pattern = 8'hFF;
            end else begin
                bus.start    = 1'($urandom);
                bus.pattern  = 8'($urandom);
                bus.length   = 4'($urandom);
                bus.repeat_n = 4'($urandom);
            end
            @(posedge clock); #1;
        end
        check($sformatf("busy_cycles p=%02h l=%0d r=%0d", pat, len, rep),
              32'(busy_n), 32'((rep + 1) * len + rep * GAP + 1));
    endtask

    task automatic loopback(input logic [7:0] pat, input int exp_z_at);
        logic [3:0] hist;
        int n;
        int z_at;
        hist = 4'd0;
        n    = 0;
        z_at = 0;
        launch(pat, 4, 0);
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (bus.w_valid) begin
                hist = {hist[2:0], bus.w};
                n++;
                if (n >= 4 && (hist == 4'b1101 || hist == 4'b1111) && z_at == 0) z_at = n;
            end
            @(posedge clock); #1;
        end
        check($sformatf("loopback_z_at p=%02h", pat), 32'(z_at), 32'(exp_z_at));
    endtask

    initial begin
        logic [7:0] rp;
        int rl;
        int rr;
        n_err        = 0;
        n_checks     = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.pattern  = 8'h00;
        bus.length   = 4'd0;
        bus.repeat_n = 4'd0;

        #1 reset = 1'b1;
        #2 check("reset_outputs", 32'(obs()), 32'd0);
        @(posedge clock); #1;
        check("reset_held_edge", 32'(obs()), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_after_reset", 32'(obs()), 32'd0);

        launch(8'h0D, 4, 0);
        expect_run(8'h0D, 4, 0, 1, 1'b0, 8'h00, 0, 0);
        launch(8'h0F, 4, 1);
        expect_run(8'h0F, 4, 1, 1, 1'b0, 8'h00, 0, 0);
        launch(8'hA5, 8, 0);
        expect_run(8'hA5, 8, 0, 1, 1'b0, 8'h00, 0, 0);

        bus.pattern = 8'hFF;
        bus.start   = 1'b1;
        foreach (rp[b]) begin end
        bus.length = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check($sformatf("len0_ignored k%0d", k), 32'(obs()), 32'd0);
        end
        bus.length = 4'd9;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check($sformatf("len9_ignored k%0d", k), 32'(obs()), 32'd0);
        end
        bus.start = 1'b0;

        launch(8'h0D, 4, 0);
        expect_run(8'h0D, 4, 0, 0, 1'b0, 8'h00, 0, 0);
        @(posedge clock); #1;
        check("no_second_run", 32'(obs()), 32'd0);

        launch(8'h0F, 4, 2);
        bus.start = 1'b0;
        @(posedge clock); #1;
        #3 reset = 1'b1;
        #1 check("async_reset_mid_shift", 32'(obs()), 32'd0);
        @(posedge clock); #1;
        check("reset_held_mid_run", 32'(obs()), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_after_mid_reset", 32'(obs()), 32'd0);
        launch(8'h0D, 4, 0);
        expect_run(8'h0D, 4, 0, 1, 1'b0, 8'h00, 0, 0);

        launch(8'h81, 8, 0);
        expect_run(8'h81, 8, 0, 1, 1'b1, 8'h3C, 6, 1);
        expect_run(8'h3C, 6, 1, 1, 1'b0, 8'h00, 0, 0);

        loopback(8'h0F, 4);
        loopback(8'h0B, 0);

        for (int it = 0; it < 25; it++) begin
            rp = 8'($urandom);
            rl = int'($urandom_range(8, 1));
            rr = int'($urandom_range(3, 0));
            launch(rp, rl, rr);
            expect_run(rp, rl, rr, 1, 1'b0, 8'h00, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Serial bit-stream transmitter: the driving end of the single-bit `w` input that the lab sequence-detector FSMs sample.
- Latches a programmed pattern of 1..MAX_LEN bits and shifts it out MSB-first, one bit per clock.
- Optionally repeats the pattern, separated by forced-zero gap cycles, then pulses `done`.
- Used on the board and in benches to drive detector FSMs with deterministic sequences in place of hand-toggled switches.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits; the `pattern` port width.
- GAP_CYCLES, 2, cycles of `w`=0 with `w_valid`=0 inserted between repeats; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset; forces IDLE and clears all registers immediately.
- start  in  1  request to transmit; sampled only in IDLE.
- pattern  in  MAX_LEN  bits to send; the transmitted bits are `pattern[length-1:0]`, MSB first.
- length  in  4  number of bits to send; legal range 1..MAX_LEN.
- repeat_n  in  4  extra repetitions; total transmissions = `repeat_n`+1.
- w  out  1  serial data bit; 0 whenever not in SHIFT.
- w_valid  out  1  high exactly on cycles where `w` carries a pattern bit.
- busy  out  1  high in SHIFT, GAP and DONE.
- done  out  1  one-cycle pulse on completion of the final transmission.
- state  out  3  current state encoding, for LEDR display.

Behaviour:
- State encoding: IDLE=3'b000, SHIFT=3'b001, GAP=3'b010, DONE=3'b011. Other codes go to IDLE on the next edge.
- Next-state logic, register block and output logic are kept separate.
- Reset (asynchronous, any cycle including mid-SHIFT or mid-GAP):
  - state=IDLE; shift register, bit counter, repeat counter and gap counter all cleared.
  - All outputs 0 while `reset` is high and until the next start.
- IDLE:
  - Accepted start: `start`=1 and 1<=`length`<=MAX_LEN.
  - On the accepting edge, latch `len_r`=`length`, `pat_r`=`pattern`, `rep_r`=`repeat_n`.
  - Load the shift register left-aligned: `sh`=`pattern`<<(MAX_LEN-`length`).
  - Set bit counter=`length`; next state=SHIFT.
  - `length`=0 or `length`>MAX_LEN: start is ignored and the block stays in IDLE.
- SHIFT:
  - `w`=`sh`[MAX_LEN-1], `w_valid`=1.
  - Each edge: `sh` shifts left by 1 with zero fill; bit counter decrements.
  - When bit counter==1 at the edge (last bit):
    - `rep_r`>0: next state=GAP, gap counter=GAP_CYCLES, `rep_r` decrements.
    - `rep_r`==0: next state=DONE.
- GAP:
  - `w`=0, `w_valid`=0; gap counter decrements each edge.
  - When gap counter==1: reload `sh` from `pat_r`/`len_r` (left-aligned), bit counter=`len_r`, next state=SHIFT.
- DONE: `done`=1 for exactly one cycle; next state=IDLE unconditionally.
- Latency:
  - First bit on `w` appears in the cycle after the accepting edge.
  - A transmission of L bits occupies exactly L SHIFT cycles.
  - Total busy cycles = (`repeat_n`+1)·L + `repeat_n`·GAP_CYCLES + 1.
- Input changes while busy:
  - `start` is ignored while `busy`=1; no queuing and no restart.
  - Changes to `pattern`, `length` or `repeat_n` while busy have no effect, because only the latched copies are used.
- Back-to-back: `start` held high through DONE is accepted in the IDLE cycle that follows, giving exactly one idle cycle between runs.
- `w` and `w_valid` are combinational from registered state only, so they are glitch-free relative to `clock`.

Test Plan:
- `pattern`=8'h0D, `length`=4, `repeat_n`=0, pulse `start` -> `w`=1,1,0,1 with `w_valid`=1 on cycles 1-4 after accept; `done`=1 on cycle 5; `state` back to 000 on cycle 6.
- `pattern`=8'h0F, `length`=4, `repeat_n`=1, GAP_CYCLES=2 -> `w`=1,1,1,1,(0,0 with `w_valid`=0),1,1,1,1; `done` at cycle 11; `busy` high for 11 cycles.
- `pattern`=8'hA5, `length`=8 -> `w`=1,0,1,0,0,1,0,1 MSB-first; `length`=0 or 9 with `start`=1 -> stays IDLE, `busy`=0, `w_valid`=0.
- Start a run with 8'h0D/4, then assert `start` and change `pattern` to 8'hFF at SHIFT cycle 2 -> stream unchanged (1,1,0,1); a single `done`; no second run.
- Assert `reset` asynchronously mid-SHIFT, between clock edges -> `state`=000 and `w`/`w_valid`/`busy`/`done`=0 before the next edge; a following start runs normally.
- Loopback into the 1101/1111 detector, `pattern`=8'h0F, `length`=4 -> detector output `z` asserts after the 4th bit; `pattern`=8'h0B (1011) -> `z` never asserts.
